mem_wb_register: RTL and testbench

Pipeline register between the memory stage (M) and the writeback stage (W) of the 5-stage RV32I core. It captures all M-stage results on each enabled clock edge. During capture it aligns and sign- or zero-extends load data, so the W-stage result mux receives a final 32-bit load value. It also supports stall and flush, suppresses writes to x0 and misaligned loads, and keeps a retired-instruction counter.

---
 rtl/mem_wb_register.sv | 204 ++++++++++++++++++++
 tb/tb_mem_wb_register.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_register.sv
// -----------------------------------------------------------------------------
// mem_wb_register
//
// Pipeline register between the memory (M) and writeback (W) stages of the
// 5-stage RV32I core. On each enabled edge it captures the M-stage results.
// Load data is aligned and sign/zero-extended before the register, so the
// W-stage result mux receives a final 32-bit load value. The register also
// supports stall and flush, suppresses writes to x0 and misaligned loads, and
// keeps a retired-instruction counter.
//
// Edge priority: reset > flush > hold > capture.
//
// Ports
//   iClk            clock, rising edge
//   iRstN           synchronous reset, active-low; clears every output
//   iEnM            1 = capture M inputs, 0 = hold (stall)
//   iFlushM         1 = load a bubble, also while iEnM=0
//   iValidM         M-stage instruction is valid
//   iRegWriteM      instruction writes rd
//   iResultSrcM     writeback select (000 ALU, 001 load, 010 PC+4, 011 LUI,
//                   100 AUIPC)
//   iLoadTypeM      funct3 of the load
//   iRdM            destination register
//   iAluResultM     ALU result; for loads, the byte address
//   iMemReadDataM   raw word-aligned word read from data memory
//   iPCM            instruction PC
//   iUpperImmM      U-type immediate
//   oValidW         registered valid
//   oRegWriteW      qualified register-file write enable
//   oResultSrcW     registered writeback select
//   oRdW            registered rd
//   oAluResultW     registered ALU result
//   oMemDataOutW    aligned and extended load data (raw word for non-loads)
//   oPCW            registered PC
//   oUpperImmW      registered immediate
//   oMisalignW      the instruction in W was a misaligned load
//   oRetireCountW   count of valid, non-faulting instructions captured
// -----------------------------------------------------------------------------
module mem_wb_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      iClk,
    input  logic                      iRstN,
    input  logic                      iEnM,
    input  logic                      iFlushM,
    input  logic                      iValidM,
    input  logic                      iRegWriteM,
    input  logic [2:0]                iResultSrcM,
    input  logic [2:0]                iLoadTypeM,
    input  logic [REG_ADDR_WIDTH-1:0] iRdM,
    input  logic [DATA_WIDTH-1:0]     iAluResultM,
    input  logic [DATA_WIDTH-1:0]     iMemReadDataM,
    input  logic [DATA_WIDTH-1:0]     iPCM,
    input  logic [DATA_WIDTH-1:0]     iUpperImmM,
    output logic                      oValidW,
    output logic                      oRegWriteW,
    output logic [2:0]                oResultSrcW,
    output logic [REG_ADDR_WIDTH-1:0] oRdW,
    output logic [DATA_WIDTH-1:0]     oAluResultW,
    output logic [DATA_WIDTH-1:0]     oMemDataOutW,
    output logic [DATA_WIDTH-1:0]     oPCW,
    output logic [DATA_WIDTH-1:0]     oUpperImmW,
    output logic                      oMisalignW,
    output logic [DATA_WIDTH-1:0]     oRetireCountW
);

    localparam logic [2:0] SRC_LOAD = 3'b001;
    localparam logic [2:0] LT_LB    = 3'b000;
    localparam logic [2:0] LT_LH    = 3'b001;
    localparam logic [2:0] LT_LW    = 3'b010;
    localparam logic [2:0] LT_LBU   = 3'b100;
    localparam logic [2:0] LT_LHU   = 3'b101;

    // Byte/halfword lane select and extension. Halfword select uses only a[1],
    // so a misaligned halfword still returns the enclosing aligned halfword.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [2:0]            lt,
        input logic [1:0]            a,
        input logic [DATA_WIDTH-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (lt)
            LT_LB:   format_load = {{24{b[7]}}, b};
            LT_LBU:  format_load = {24'd0, b};
            LT_LH:   format_load = {{16{h[15]}}, h};
            LT_LHU:  format_load = {16'd0, h};
            default: format_load = w;
        endcase
    endfunction

    logic                      valid_q,     valid_d;
    logic                      regwrite_q,  regwrite_d;
    logic [2:0]                resultsrc_q, resultsrc_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic [DATA_WIDTH-1:0]     alu_q,       alu_d;
    logic [DATA_WIDTH-1:0]     memdata_q,   memdata_d;
    logic [DATA_WIDTH-1:0]     pc_q,        pc_d;
    logic [DATA_WIDTH-1:0]     uimm_q,      uimm_d;
    logic                      misalign_q,  misalign_d;
    logic [DATA_WIDTH-1:0]     retire_cnt_q, retire_cnt_d;

    logic                      is_load_m;
    logic                      misalign_m;
    logic [1:0]                addr_lo_m;
    logic [DATA_WIDTH-1:0]     load_data_m;

    // M-stage decode: misalignment is only meaningful for valid loads.
    always_comb begin
        addr_lo_m  = iAluResultM[1:0];
        is_load_m  = iValidM && (iResultSrcM == SRC_LOAD);
        misalign_m = 1'b0;
        if (is_load_m) begin
            if ((iLoadTypeM == LT_LH) || (iLoadTypeM == LT_LHU)) begin
                misalign_m = addr_lo_m[0];
            end else if (iLoadTypeM == LT_LW) begin
                misalign_m = (addr_lo_m != 2'b00);
            end
        end
        load_data_m = (iResultSrcM == SRC_LOAD)
                    ? format_load(iLoadTypeM, addr_lo_m, iMemReadDataM)
                    : iMemReadDataM;
    end

    // Next state: flush > hold > capture; the counter only moves on capture.
    always_comb begin
        valid_d      = valid_q;
        regwrite_d   = regwrite_q;
        resultsrc_d  = resultsrc_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        memdata_d    = memdata_q;
        pc_d         = pc_q;
        uimm_d       = uimm_q;
        misalign_d   = misalign_q;
        retire_cnt_d = retire_cnt_q;
        if (iFlushM) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            resultsrc_d = '0;
            rd_d        = '0;
            alu_d       = '0;
            memdata_d   = '0;
            pc_d        = '0;
            uimm_d      = '0;
            misalign_d  = 1'b0;
        end else if (iEnM) begin
            valid_d     = iValidM;
            regwrite_d  = iValidM && iRegWriteM && (iRdM != '0) && !misalign_m;
            resultsrc_d = iResultSrcM;
            rd_d        = iRdM;
            alu_d       = iAluResultM;
            memdata_d   = load_data_m;
            pc_d        = iPCM;
            uimm_d      = iUpperImmM;
            misalign_d  = misalign_m;
            if (iValidM && !misalign_m) begin
                retire_cnt_d = retire_cnt_q + 1'b1;
            end
        end
    end

    // ---- M -> W register boundary ----
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            resultsrc_q  <= '0;
            rd_q         <= '0;
            alu_q        <= '0;
            memdata_q    <= '0;
            pc_q         <= '0;
            uimm_q       <= '0;
            misalign_q   <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            resultsrc_q  <= resultsrc_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            memdata_q    <= memdata_d;
            pc_q         <= pc_d;
            uimm_q       <= uimm_d;
            misalign_q   <= misalign_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign oValidW       = valid_q;
    assign oRegWriteW    = regwrite_q;
    assign oResultSrcW   = resultsrc_q;
    assign oRdW          = rd_q;
    assign oAluResultW   = alu_q;
    assign oMemDataOutW  = memdata_q;
    assign oPCW          = pc_q;
    assign oUpperImmW    = uimm_q;
    assign oMisalignW    = misalign_q;
    assign oRetireCountW = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_register.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_register
//
// Directed bench for mem_wb_register: reset, load formatting, misalignment,
// x0 suppression, stall/flush, reset during stall and counter wrap.
// -----------------------------------------------------------------------------
module tb_mem_wb_register;

    logic        iClk;
    logic        iRstN;
    logic        iEnM;
    logic        iFlushM;
    logic        iValidM;
    logic        iRegWriteM;
    logic [2:0]  iResultSrcM;
    logic [2:0]  iLoadTypeM;
    logic [4:0]  iRdM;
    logic [31:0] iAluResultM;
    logic [31:0] iMemReadDataM;
    logic [31:0] iPCM;
    logic [31:0] iUpperImmM;
    logic        oValidW;
    logic        oRegWriteW;
    logic [2:0]  oResultSrcW;
    logic [4:0]  oRdW;
    logic [31:0] oAluResultW;
    logic [31:0] oMemDataOutW;
    logic [31:0] oPCW;
    logic [31:0] oUpperImmW;
    logic        oMisalignW;
    logic [31:0] oRetireCountW;

    int vectors;
    int miscompares;

    localparam logic [31:0] W = 32'h80FF_7F01;

    mem_wb_register #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .iClk         (iClk),
        .iRstN        (iRstN),
        .iEnM         (iEnM),
        .iFlushM      (iFlushM),
        .iValidM      (iValidM),
        .iRegWriteM   (iRegWriteM),
        .iResultSrcM  (iResultSrcM),
        .iLoadTypeM   (iLoadTypeM),
        .iRdM         (iRdM),
        .iAluResultM  (iAluResultM),
        .iMemReadDataM(iMemReadDataM),
        .iPCM         (iPCM),
        .iUpperImmM   (iUpperImmM),
        .oValidW      (oValidW),
        .oRegWriteW   (oRegWriteW),
        .oResultSrcW  (oResultSrcW),
        .oRdW         (oRdW),
        .oAluResultW  (oAluResultW),
        .oMemDataOutW (oMemDataOutW),
        .oPCW         (oPCW),
        .oUpperImmW   (oUpperImmW),
        .oMisalignW   (oMisalignW),
        .oRetireCountW(oRetireCountW)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [2:0] src,
                         input logic [2:0] lt, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [31:0] uimm);
        iValidM       = v;
        iRegWriteM    = rw;
        iResultSrcM   = src;
        iLoadTypeM    = lt;
        iRdM          = rd;
        iAluResultM   = alu;
        iMemReadDataM = mem;
        iPCM          = pc;
        iUpperImmM    = uimm;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        iRstN = 1'b0; iEnM = 1'b1; iFlushM = 1'b0;
        set_m(1'b1, 1'b1, 3'b001, 3'b000, 5'd3, 32'h0, W, 32'h0, 32'h0);

        // Reset for two edges with random inputs
        for (int i = 0; i < 2; i++) begin
            set_m(1'b1, 1'b1, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                  5'($urandom_range(1, 31)), $urandom, $urandom, $urandom, $urandom);
            tick();
        end
        chk("rst_valid",    {31'd0, oValidW},     32'd0);
        chk("rst_regwrite", {31'd0, oRegWriteW},  32'd0);
        chk("rst_src",      {29'd0, oResultSrcW}, 32'd0);
        chk("rst_rd",       {27'd0, oRdW},        32'd0);
        chk("rst_alu",      oAluResultW,          32'd0);
        chk("rst_mem",      oMemDataOutW,         32'd0);
        chk("rst_pc",       oPCW,                 32'd0);
        chk("rst_uimm",     oUpperImmW,           32'd0);
        chk("rst_misalign", {31'd0, oMisalignW},  32'd0);
        chk("rst_count",    oRetireCountW,        32'd0);

        // Release with a valid ALU instruction
        iRstN = 1'b1;
        set_m(1'b1, 1'b1, 3'b000, 3'b000, 5'd5, 32'h10, 32'h0, 32'h400, 32'h0);
        tick();
        chk("rel_regwrite", {31'd0, oRegWriteW}, 32'd1);
        chk("rel_rd",       {27'd0, oRdW},       32'd5);
        chk("rel_alu",      oAluResultW,         32'h10);
        chk("rel_count",    oRetireCountW,       32'd1);

        // Load formatting with w = 0x80FF_7F01
        set_m(1'b1, 1'b1, 3'b001, 3'b000, 5'd3, 32'h100, W, 32'h404, 32'h0);
        tick();
        chk("lb_a0", oMemDataOutW, 32'h0000_0001);
        chk("lb_a0_count", oRetireCountW, 32'd2);
        set_m(1'b1, 1'b1, 3'b001, 3'b000, 5'd3, 32'h103, W, 32'h408, 32'h0);
        tick();
        chk("lb_a3", oMemDataOutW, 32'hFFFF_FF80);
        set_m(1'b1, 1'b1, 3'b001, 3'b100, 5'd3, 32'h103, W, 32'h40C, 32'h0);
        tick();
        chk("lbu_a3", oMemDataOutW, 32'h0000_0080);
        set_m(1'b1, 1'b1, 3'b001, 3'b001, 5'd3, 32'h102, W, 32'h410, 32'h0);
        tick();
        chk("lh_a2", oMemDataOutW, 32'hFFFF_80FF);
        chk("lh_a2_misalign", {31'd0, oMisalignW}, 32'd0);
        set_m(1'b1, 1'b1, 3'b001, 3'b101, 5'd3, 32'h102, W, 32'h414, 32'h0);
        tick();
        chk("lhu_a2", oMemDataOutW, 32'h0000_80FF);
        set_m(1'b1, 1'b1, 3'b001, 3'b010, 5'd3, 32'h100, W, 32'h418, 32'h0);
        tick();
        chk("lw", oMemDataOutW, W);
        chk("lw_regwrite", {31'd0, oRegWriteW}, 32'd1);
        chk("lw_count", oRetireCountW, 32'd7);

        // Misaligned LW: no write, counter holds
        set_m(1'b1, 1'b1, 3'b001, 3'b010, 5'd3, 32'h101, W, 32'h41C, 32'h0);
        tick();
        chk("lw_a1_misalign", {31'd0, oMisalignW}, 32'd1);
        chk("lw_a1_regwrite", {31'd0, oRegWriteW}, 32'd0);
        chk("lw_a1_count",    oRetireCountW,       32'd7);
        chk("lw_a1_data",     oMemDataOutW,        W);
        // Misaligned LH still formats from the low halfword
        set_m(1'b1, 1'b1, 3'b001, 3'b001, 5'd3, 32'h101, W, 32'h420, 32'h0);
        tick();
        chk("lh_a1_misalign", {31'd0, oMisalignW}, 32'd1);
        chk("lh_a1_data",     oMemDataOutW,        32'h0000_7F01);
        chk("lh_a1_count",    oRetireCountW,       32'd7);
        // ALU op with odd address: not a misalignment, raw word passes
        set_m(1'b1, 1'b1, 3'b000, 3'b010, 5'd4, 32'h201, W, 32'h424, 32'h0);
        tick();
        chk("alu_a1_misalign", {31'd0, oMisalignW}, 32'd0);
        chk("alu_a1_regwrite", {31'd0, oRegWriteW}, 32'd1);
        chk("alu_a1_data",     oMemDataOutW,        W);
        chk("alu_a1_count",    oRetireCountW,       32'd8);

        // x0 suppression, counter still advances
        set_m(1'b1, 1'b1, 3'b000, 3'b000, 5'd0, 32'h33, 32'h0, 32'h428, 32'h0);
        tick();
        chk("x0_regwrite", {31'd0, oRegWriteW}, 32'd0);
        chk("x0_count",    oRetireCountW,       32'd9);
        // Invalid misaligned load: no misalign flag, no count
        set_m(1'b0, 1'b1, 3'b001, 3'b010, 5'd6, 32'h301, W, 32'h42C, 32'h0);
        tick();
        chk("inv_misalign", {31'd0, oMisalignW}, 32'd0);
        chk("inv_valid",    {31'd0, oValidW},    32'd0);
        chk("inv_count",    oRetireCountW,       32'd9);

        // Stall: capture one instruction, then hold 3 cycles with changing inputs
        set_m(1'b1, 1'b1, 3'b011, 3'b000, 5'd7, 32'hAAAA_0000, 32'hDEAD_BEEF, 32'h1000, 32'h1234_5000);
        tick();
        chk("pre_stall_count", oRetireCountW, 32'd10);
        chk("pre_stall_uimm",  oUpperImmW,    32'h1234_5000);
        iEnM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_m(1'b1, 1'b1, 3'b000, 3'b000, 5'(10 + i), 32'h5000 + 32'(i), 32'h0, 32'h3000, 32'h0);
            tick();
            chk("stall_alu",   oAluResultW,   32'hAAAA_0000);
            chk("stall_pc",    oPCW,          32'h1000);
            chk("stall_rd",    {27'd0, oRdW}, 32'd7);
            chk("stall_count", oRetireCountW, 32'd10);
        end
        // Flush while stalled
        iFlushM = 1'b1;
        tick();
        chk("flush_valid",    {31'd0, oValidW},    32'd0);
        chk("flush_regwrite", {31'd0, oRegWriteW}, 32'd0);
        chk("flush_count",    oRetireCountW,       32'd10);
        // Resume
        iFlushM = 1'b0; iEnM = 1'b1;
        set_m(1'b1, 1'b1, 3'b010, 3'b000, 5'd9, 32'h55, 32'h0, 32'h2000, 32'h0);
        tick();
        chk("resume_valid", {31'd0, oValidW},     32'd1);
        chk("resume_rd",    {27'd0, oRdW},        32'd9);
        chk("resume_alu",   oAluResultW,          32'h55);
        chk("resume_pc",    oPCW,                 32'h2000);
        chk("resume_src",   {29'd0, oResultSrcW}, 32'd2);
        chk("resume_count", oRetireCountW,        32'd11);

        // Reset during a stall wins; counter restarts
        iEnM = 1'b0; iRstN = 1'b0;
        tick();
        chk("rst_stall_count", oRetireCountW, 32'd0);
        chk("rst_stall_alu",   oAluResultW,   32'd0);
        iRstN = 1'b1; iEnM = 1'b1;
        set_m(1'b1, 1'b0, 3'b000, 3'b000, 5'd2, 32'h77, 32'h0, 32'h2004, 32'h0);
        tick();
        chk("post_rst_count",    oRetireCountW,       32'd1);
        chk("post_rst_regwrite", {31'd0, oRegWriteW}, 32'd0);

        // Counter wrap: deposit 0xFFFF_FFFF across a hold edge
        iEnM = 1'b0;
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.retire_cnt_q;
        #1;
        chk("preload_count", oRetireCountW, 32'hFFFF_FFFF);
        iEnM = 1'b1;
        set_m(1'b1, 1'b1, 3'b000, 3'b000, 5'd8, 32'h88, 32'h0, 32'h2008, 32'h0);
        tick();
        chk("wrap_count", oRetireCountW, 32'd0);
        tick();
        chk("after_wrap_count", oRetireCountW, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
